// File: rtl/fir_ctrl_pkg.sv
// Shared types for the FIR accelerator sequencing controller.
package fir_ctrl_pkg;

  localparam int unsigned FIR_LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } fir_ctrl_state_t;

  typedef struct packed {
    logic [FIR_LEN_WIDTH-1:0] len;
    logic                     reuse_taps;
  } fir_ctrl_cfg_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    fir_ctrl_state_t state;
  } fir_ctrl_flags_t;

endpackage

// File: rtl/fir_ctrl_counter.sv
// Output-handshake counter with synchronous clear, enable and terminal-count compare.
module fir_ctrl_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/fir_ctrl.sv
// FIR accelerator sequencer: tap reload via the h streamer, then x/y streaming
// for a programmed number of output samples, with done event and abort.
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NB_TAPS   = 8,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 cfg_reuse_taps_i,
  input  logic                 tap_done_i,
  input  logic                 y_valid_i,
  input  logic                 y_ready_i,
  output logic                 clear_o,
  output logic                 h_start_o,
  output logic [LEN_WIDTH-1:0] h_len_o,
  output logic                 x_start_o,
  output logic                 y_start_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic [LEN_WIDTH-1:0] y_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           state_o
);

  fir_ctrl_state_t      state_d, state_q;
  logic [LEN_WIDTH-1:0] len_d, len_q;
  logic                 taps_valid_d, taps_valid_q;
  logic                 cnt_clr, cnt_en, cnt_tc;
  logic                 y_hs;
  fir_ctrl_flags_t      flags;

  assign y_hs = y_valid_i & y_ready_i;

  fir_ctrl_counter #(
    .WIDTH (LEN_WIDTH)
  ) i_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .term_i  (len_q - LEN_WIDTH'(1)),
    .count_o (y_count_o),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    taps_valid_d = taps_valid_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    // Abort wins over everything, including a coincident start.
    if (clear_i) begin
      state_d      = ST_IDLE;
      taps_valid_d = 1'b0;
      cnt_clr      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_d   = cfg_len_i;
            cnt_clr = 1'b1;
            if (cfg_len_i == '0) begin
              state_d = ST_DONE;
            end else if (cfg_reuse_taps_i && taps_valid_q) begin
              state_d = ST_START;
            end else begin
              state_d = ST_CLR;
            end
          end
        end
        ST_CLR: begin
          taps_valid_d = 1'b0;
          state_d      = ST_LOAD;
        end
        ST_LOAD: begin
          if (tap_done_i) begin
            taps_valid_d = 1'b1;
            state_d      = ST_START;
          end
        end
        ST_START: state_d = ST_RUN;
        ST_RUN: begin
          if (y_hs) begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      taps_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      taps_valid_q <= taps_valid_d;
    end
  end

  assign flags.busy  = (state_q != ST_IDLE);
  assign flags.done  = (state_q == ST_DONE);
  assign flags.state = state_q;

  assign clear_o   = clear_i | (state_q == ST_CLR);
  assign h_start_o = (state_q == ST_CLR);
  assign h_len_o   = LEN_WIDTH'(NB_TAPS);
  assign x_start_o = (state_q == ST_START);
  assign y_start_o = (state_q == ST_START);
  assign len_o     = len_q;
  assign busy_o    = flags.busy;
  assign done_o    = flags.done;
  assign state_o   = flags.state;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed, table-driven bench for fir_ctrl (NB_TAPS=4).
module tb_fir_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0, start_i = 1'b0, cfg_reuse_taps_i = 1'b0;
  logic        tap_done_i = 1'b0, y_valid_i = 1'b0, y_ready_i = 1'b0;
  logic [15:0] cfg_len_i = '0;
  logic        clear_o, h_start_o, x_start_o, y_start_o, busy_o, done_o;
  logic [15:0] h_len_o, len_o, y_count_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fir_ctrl #(.NB_TAPS(4), .LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .cfg_len_i(cfg_len_i), .cfg_reuse_taps_i(cfg_reuse_taps_i),
    .tap_done_i(tap_done_i), .y_valid_i(y_valid_i), .y_ready_i(y_ready_i),
    .clear_o(clear_o), .h_start_o(h_start_o), .h_len_o(h_len_o),
    .x_start_o(x_start_o), .y_start_o(y_start_o), .len_o(len_o),
    .y_count_o(y_count_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  typedef struct {
    logic        clr, st;
    logic [15:0] len;
    logic        reuse, tapd, yv, yr;
    logic        e_clr, e_hs, e_xs, e_busy, e_done;
    logic [2:0]  e_st;
    logic [15:0] e_cnt, e_len;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic clr, logic st, int len, logic reuse, logic tapd,
                             logic yv, logic yr, logic e_clr, logic e_hs, logic e_xs,
                             logic e_busy, logic e_done, int e_st, int e_cnt, int e_len);
    vec_t r;
    r.clr = clr; r.st = st; r.len = 16'(len); r.reuse = reuse; r.tapd = tapd;
    r.yv = yv; r.yr = yr; r.e_clr = e_clr; r.e_hs = e_hs; r.e_xs = e_xs;
    r.e_busy = e_busy; r.e_done = e_done; r.e_st = 3'(e_st);
    r.e_cnt = 16'(e_cnt); r.e_len = 16'(e_len);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    clear_i = r.clr; start_i = r.st; cfg_len_i = r.len; cfg_reuse_taps_i = r.reuse;
    tap_done_i = r.tapd; y_valid_i = r.yv; y_ready_i = r.yr;
  endtask

  initial begin
    int cyc;
    // Rows: inputs applied in a cycle, outputs expected in that same cycle.
    // v(clr,st,len,reuse,tapd,yv,yr, clr_o,h_start,xy_start,busy,done,state,y_count,len_o)
    // Normal job, len=5
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,5,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,1,0,1,0,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,0,2,0,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,0,2,0,5));
    vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1,0,2,0,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,1,1,0,3,0,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,0,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,1,5));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,0,4,2,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,2,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,3,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,4,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,5,5,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,5,5));
    // Reuse taps, len=3
    vecs.push_back(v(0,1,3,1,0,0,0, 0,0,0,0,0,0,5,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,1,1,0,3,0,3));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,0,3));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,1,3));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,2,3));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,5,3,3));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,3));
    // len=0
    vecs.push_back(v(0,1,0,0,0,0,0, 0,0,0,0,0,0,3,3));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,5,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    // Backpressure, len=4, ready 1,0,0,1,0,1,1
    vecs.push_back(v(0,1,4,1,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,1,1,0,3,0,4));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,0,4));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,0,4,1,4));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,0,4,1,4));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,1,4));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,0,4,2,4));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,2,4));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,3,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,5,4,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,4,4));
    // Abort in RUN at y_count=2, then reuse start must reload taps
    vecs.push_back(v(0,1,5,1,0,0,0, 0,0,0,0,0,0,4,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,1,1,0,3,0,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,0,5));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,1,5));
    vecs.push_back(v(1,0,0,0,0,1,1, 1,0,0,1,0,4,2,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,5));
    vecs.push_back(v(0,1,2,1,0,0,0, 0,0,0,0,0,0,0,5));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,1,0,1,0,2));
    // start during LOAD ignored
    vecs.push_back(v(0,1,7,0,0,0,0, 0,0,0,1,0,2,0,2));
    vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1,0,2,0,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,1,1,0,3,0,2));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,0,2));
    vecs.push_back(v(0,0,0,0,0,1,1, 0,0,0,1,0,4,1,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,5,2,2));
    // start and clear together in IDLE
    vecs.push_back(v(1,1,9,0,0,0,0, 1,0,0,0,0,0,2,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,2));

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("h_len", 0, 32'(h_len_o), 32'd4);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      drive(vecs[i]);
      @(negedge clk_i);
      chk("clear_o",   i, 32'(clear_o),   32'(vecs[i].e_clr));
      chk("h_start_o", i, 32'(h_start_o), 32'(vecs[i].e_hs));
      chk("x_start_o", i, 32'(x_start_o), 32'(vecs[i].e_xs));
      chk("y_start_o", i, 32'(y_start_o), 32'(vecs[i].e_xs));
      chk("busy_o",    i, 32'(busy_o),    32'(vecs[i].e_busy));
      chk("done_o",    i, 32'(done_o),    32'(vecs[i].e_done));
      chk("state_o",   i, 32'(state_o),   32'(vecs[i].e_st));
      chk("y_count_o", i, 32'(y_count_o), 32'(vecs[i].e_cnt));
      chk("len_o",     i, 32'(len_o),     32'(vecs[i].e_len));
    end

    // Asynchronous reset while in LOAD
    @(posedge clk_i); #1;
    start_i = 1'b1; cfg_len_i = 16'd3; cfg_reuse_taps_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("pre_reset_state", 100, 32'(state_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("rst_state", 100, 32'(state_o), 32'd0);
    chk("rst_busy",  100, 32'(busy_o),  32'd0);
    chk("rst_len",   100, 32'(len_o),   32'd0);
    chk("rst_clear", 100, 32'(clear_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reuse after reset must reload taps; done 7 cycles after acceptance
    @(posedge clk_i); #1;
    start_i = 1'b1; cfg_len_i = 16'd3; cfg_reuse_taps_i = 1'b1;
    tap_done_i = 1'b1; y_valid_i = 1'b1; y_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("reload_after_reset", 101, 32'(state_o), 32'd1);
    cyc = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("done_latency", 101, 32'(cyc), 32'd7);
    chk("done_count",   101, 32'(y_count_o), 32'd3);
    y_valid_i = 1'b0; y_ready_i = 1'b0; tap_done_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_after_done", 101, 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
